word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 4 and is the number of clock cycles per serial bit (legal range 2..1023).
REQ-003 i_clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_valid  input  1  upstream 20-bit word present on i_data this cycle.
REQ-006 i_data  input  20  word from the upstream register stage.
REQ-007 o_ready  output  1  FIFO can accept a word this cycle.
REQ-008 o_tx  output  1  registered serial line; idles high.
REQ-009 o_busy  output  1  high while a frame is on o_tx.
REQ-010 o_count  output  3  FIFO occupancy, 0..4.
REQ-011 o_overflow  output  1  sticky flag for a dropped word.

Function
REQ-012 The block SHALL buffer words in a 4-entry FIFO; a word is accepted on an edge where i_valid=1 and o_ready=1.
REQ-013 o_ready SHALL equal (o_count != 4), derived only from registered occupancy.
REQ-014 A push and a pop on the same edge SHALL leave o_count unchanged and SHALL preserve both words.
REQ-015 i_valid=1 while o_ready=0 SHALL drop the word, leave the FIFO unchanged, and set o_overflow to 1 until reset.
REQ-016 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-017 IDLE: if the FIFO is non-empty, the head SHALL be popped into a 20-bit shift register, a 5-bit bit index cleared, and the state set to START; otherwise the FSM SHALL stay in IDLE.
REQ-018 START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA: the block SHALL send 20 bits MSB first, each for CLKS_PER_BIT cycles, then go to STOP after the bit with index 19.
REQ-020 STOP: o_tx=1 for CLKS_PER_BIT cycles.
REQ-021 At the end of STOP, if the FIFO is non-empty, the block SHALL pop and enter START directly with no idle gap; otherwise it SHALL enter IDLE.
REQ-022 Frame length SHALL be exactly 22*CLKS_PER_BIT cycles.
REQ-023 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary.
REQ-024 The first low cycle of o_tx SHALL be the second rising edge after the edge that accepted the word into an empty, idle block.
REQ-025 o_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 The FIFO pointers SHALL be 2 bits wide and wrap modulo 4.

Reset
REQ-027 While i_rst=1 at a rising edge, the block SHALL set: FSM=IDLE, FIFO flushed (o_count=0), pointers=0, o_tx=1, o_busy=0, o_overflow=0, o_ready=1, and baud and bit counters=0.
REQ-028 Reset mid-frame SHALL abort the frame, return o_tx to 1 on the next edge, and discard the shift register and FIFO contents.
REQ-029 Words presented while i_rst=1 SHALL NOT be accepted.

Verification (CLKS_PER_BIT=4)
REQ-030 Reset: i_rst high for 2 cycles -> o_tx=1, o_busy=0, o_ready=1, o_count=0, o_overflow=0.
REQ-031 Single word 20'hA5F0C: the bench SHALL check 4 low cycles, then bits 1010_0101_1111_0000_1100 at 4 cycles each, then 4 high cycles; o_busy SHALL be high for exactly 88 cycles.
REQ-032 Overflow: 6 consecutive words pushed into an idle block -> word 1 in the shifter, words 2..5 in the FIFO, o_count=4, o_ready=0; word 6 is dropped and o_overflow=1. All five accepted frames SHALL then appear in order.
REQ-033 Back-to-back: 20'hFFFFF then 20'h00000 -> 176 busy cycles with o_busy never dropping, and the stop bit directly followed by the next start bit.
REQ-034 Reset mid-frame: i_rst pulsed for 1 cycle 30 cycles into a frame -> o_tx=1 and o_count=0 on the next edge; a subsequent word 20'h12345 SHALL frame correctly.
REQ-035 Simultaneous push and pop: a push on the same edge the FSM pops from o_count=2 -> o_count stays 2, and output order is preserved.

Source files
------------

// File: rtl/word_serializer.sv
// 20-bit word serializer: 4-entry FIFO feeding a start/20-data/stop serial framer.
// o_tx and o_busy are registered together so o_busy brackets exactly the frame on the line.
module word_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [19:0] i_data,
  output logic        o_ready,
  output logic        o_tx,
  output logic        o_busy,
  output logic [2:0]  o_count,
  output logic        o_overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [4:0]        bit_reg, bit_next;
  logic [19:0]       shift_reg, shift_next;

  logic [19:0] fifo_mem [4];
  logic [1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [2:0]  count_reg;
  logic        tx_reg, busy_reg, overflow_reg;
  logic        push, pop, baud_done, fifo_nonempty;

  assign o_ready       = (count_reg != 3'd4);
  assign push          = i_valid & o_ready;
  assign baud_done     = (baud_reg == BAUD_LAST);
  assign fifo_nonempty = (count_reg != 3'd0);

  assign o_tx       = tx_reg;
  assign o_busy     = busy_reg;
  assign o_count    = count_reg;
  assign o_overflow = overflow_reg;

  // Storage is not reset; a flush only needs the pointers and occupancy cleared.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      fifo_mem[wr_ptr_reg] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          bit_next   = '0;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {shift_reg[18:0], 1'b0};
          if (bit_reg == 5'd19) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 5'd1;
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Chain straight into the next start bit when more words are waiting.
          if (fifo_nonempty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            bit_next   = '0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
      case (state_reg)
        START:   tx_reg <= 1'b0;
        DATA:    tx_reg <= shift_reg[19];
        default: tx_reg <= 1'b1;
      endcase
      busy_reg <= (state_reg != IDLE);
      if (i_valid && !o_ready) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: accepted words are queued, a line monitor
// captures each frame on o_tx and compares it against the queued word's expected waveform.
module tb_word_serializer;

  localparam int CPB   = 4;
  localparam int FLEN  = 22 * CPB;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [19:0] i_data;
  logic        o_ready;
  logic        o_tx;
  logic        o_busy;
  logic [2:0]  o_count;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  logic [19:0] sb [$];
  bit          in_frame = 1'b0;
  int          k_idx = 0;
  logic [87:0] got_vec, exp_vec;
  logic [19:0] cur_word;

  word_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [87:0] frame_of(input logic [19:0] w);
    logic [87:0] f;
    for (int k = 0; k < FLEN; k++) begin
      if (k < CPB)             f[FLEN-1-k] = 1'b0;
      else if (k < 21 * CPB)   f[FLEN-1-k] = w[19 - (k - CPB) / CPB];
      else                     f[FLEN-1-k] = 1'b1;
    end
    return f;
  endfunction

  // Line monitor: a low level while idle starts a frame, which is captured cycle by cycle.
  always @(negedge clk) begin
    if (i_rst === 1'b1) begin
      in_frame = 1'b0;
      sb.delete();
    end else if (!in_frame) begin
      if (o_tx === 1'b0) begin
        if (sb.size() == 0) begin
          check("spurious_start", 88'(o_tx), 88'd1);
        end else begin
          cur_word = sb.pop_front();
          exp_vec  = frame_of(cur_word);
          got_vec  = '0;
          got_vec[FLEN-1] = o_tx;
          k_idx    = 1;
          in_frame = 1'b1;
        end
      end
    end else begin
      got_vec[FLEN-1-k_idx] = o_tx;
      k_idx++;
      if (k_idx == FLEN) begin
        check("frame", got_vec, exp_vec);
        $display("frame word=%05h done", cur_word);
        in_frame = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_frame || o_busy) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_timeout", 88'(n >= 3000), 88'd0);
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    int run;
    int max_run;
    logic [19:0] ovf_words [6];

    // Reset with a word presented: it must not be taken.
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_data  = 20'h55555;
    tick(2);
    i_valid = 1'b0;
    @(negedge clk);
    check("rst_tx",       88'(o_tx),       88'd1);
    check("rst_busy",     88'(o_busy),     88'd0);
    check("rst_ready",    88'(o_ready),    88'd1);
    check("rst_count",    88'(o_count),    88'd0);
    check("rst_overflow", 88'(o_overflow), 88'd0);
    tick();
    i_rst = 1'b0;
    tick(2);

    // Single word: latency of the first low cycle and busy length.
    i_valid = 1'b1;
    i_data  = 20'hA5F0C;
    sb.push_back(20'hA5F0C);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("lat_e0_tx", 88'(o_tx), 88'd1);
    tick();
    @(negedge clk);
    check("lat_e1_tx",   88'(o_tx),   88'd1);
    check("lat_e1_busy", 88'(o_busy), 88'd0);
    tick();
    @(negedge clk);
    check("first_low_tx",   88'(o_tx),   88'd0);
    check("first_low_busy", 88'(o_busy), 88'd1);
    busy_cnt = 1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
    end
    check("single_busy_cycles", 88'(busy_cnt), 88'd88);
    drain();

    // Back-to-back frames: busy must stay high through both.
    i_valid = 1'b1;
    i_data  = 20'hFFFFF;
    sb.push_back(20'hFFFFF);
    tick();
    i_data  = 20'h00000;
    sb.push_back(20'h00000);
    tick();
    i_valid  = 1'b0;
    busy_cnt = 0;
    run      = 0;
    max_run  = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (o_busy) begin
        busy_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("b2b_busy_total", 88'(busy_cnt), 88'd176);
    check("b2b_busy_run",   88'(max_run),  88'd176);
    drain();

    // Push on the same edge the end of STOP pops, with two words queued.
    i_valid = 1'b1;
    i_data  = 20'h11111;
    sb.push_back(20'h11111);
    tick();
    i_data  = 20'h22222;
    sb.push_back(20'h22222);
    tick();
    i_data  = 20'h33333;
    sb.push_back(20'h33333);
    tick();
    i_valid = 1'b0;
    tick(86);
    @(negedge clk);
    check("pp_count_before", 88'(o_count), 88'd2);
    i_valid = 1'b1;
    i_data  = 20'h44444;
    sb.push_back(20'h44444);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("pp_count_after", 88'(o_count), 88'd2);
    drain();

    // Overflow: six consecutive words into an idle block, the sixth is dropped.
    ovf_words[0] = 20'h00001;
    ovf_words[1] = 20'h80002;
    ovf_words[2] = 20'hC3C3C;
    ovf_words[3] = 20'h5A5A5;
    ovf_words[4] = 20'hFEDCB;
    ovf_words[5] = 20'h0BAD0;
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1;
      i_data  = ovf_words[i];
      if (i < 5) sb.push_back(ovf_words[i]);
      tick();
    end
    i_valid = 1'b0;
    @(negedge clk);
    check("ovf_count",    88'(o_count),    88'd4);
    check("ovf_ready",    88'(o_ready),    88'd0);
    check("ovf_overflow", 88'(o_overflow), 88'd1);
    drain();
    check("ovf_sticky", 88'(o_overflow), 88'd1);

    // Reset 30 cycles into a frame aborts it; the next word frames cleanly.
    i_valid = 1'b1;
    i_data  = 20'h0F0F0;
    sb.push_back(20'h0F0F0);
    tick();
    i_valid = 1'b0;
    tick(31);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    @(negedge clk);
    check("midrst_tx",       88'(o_tx),       88'd1);
    check("midrst_count",    88'(o_count),    88'd0);
    check("midrst_busy",     88'(o_busy),     88'd0);
    check("midrst_overflow", 88'(o_overflow), 88'd0);
    check("midrst_ready",    88'(o_ready),    88'd1);
    tick(3);
    @(negedge clk);
    check("midrst_idle_tx", 88'(o_tx), 88'd1);
    tick();
    i_valid = 1'b1;
    i_data  = 20'h12345;
    sb.push_back(20'h12345);
    tick();
    i_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
